// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit driving one port of a dual-port word memory.
// Byte-addressed byte/half/word requests come in over a valid/ready
// handshake and are turned into word accesses. Loads are lane-extracted and
// sign/zero-extended; sub-word stores are read-modify-write because the
// memory port has no byte enables.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   req_addr/wr/size/signed/wdata request fields
//   resp_valid/resp_ready         response handshake
//   resp_rdata/resp_err           load result / misalignment or bad size
//   mem_addr/mem_wdata/mem_wr     word-port command
//   mem_rdata                     word-port read data (one cycle after addr)
module mem_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_DATA, S_WR, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [29:0] maddr_q, maddr_d;

    logic        req_bad;
    logic        wr_raw;
    logic [31:0] wword;
    logic [31:0] rshift;
    logic [15:0] half;
    logic [31:0] load_ext;
    logic [31:0] merged;
    logic [4:0]  bsh;
    logic [4:0]  hsh;

    assign req_bad = (req_size == 2'b11) ||
                     (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00);

    // Lane extraction and lane merge on the word coming back from memory.
    assign bsh    = {off_q, 3'b000};
    assign hsh    = {off_q[1], 4'b0000};
    assign rshift = mem_rdata >> bsh;
    assign half   = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_ext = mem_rdata;
        merged   = mem_rdata;
        case (size_q)
            2'b00: begin
                load_ext = {{24{sgn_q & rshift[7]}}, rshift[7:0]};
                merged   = (mem_rdata & ~(32'h0000_00FF << bsh)) |
                           ({24'b0, wdata_q[7:0]} << bsh);
            end
            2'b01: begin
                load_ext = {{16{sgn_q & half[15]}}, half};
                merged   = (mem_rdata & ~(32'h0000_FFFF << hsh)) |
                           ({16'b0, wdata_q[15:0]} << hsh);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        off_d      = off_q;
        wr_d       = wr_q;
        size_d     = size_q;
        sgn_d      = sgn_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        maddr_d    = maddr_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        wr_raw     = 1'b0;
        wword      = 32'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    off_d   = req_addr[1:0];
                    wr_d    = req_wr;
                    size_d  = req_size;
                    sgn_d   = req_signed;
                    wdata_d = req_wdata;
                    rdata_d = 32'b0;
                    err_d   = req_bad;
                    if (req_bad) begin
                        state_d = S_RESP;        // no memory access at all
                    end else begin
                        maddr_d = req_addr[31:2];
                        state_d = (req_wr && req_size == 2'b10) ? S_WR : S_RD;
                    end
                end
            end
            S_RD:   state_d = S_DATA;
            S_DATA: begin
                if (wr_q) begin
                    wr_raw = 1'b1;
                    wword  = merged;
                end else begin
                    rdata_d = load_ext;
                end
                state_d = S_RESP;
            end
            S_WR: begin
                wr_raw  = 1'b1;
                wword   = wdata_q;
                state_d = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Write strobe is killed combinationally by rst so a reset landing in the
    // write cycle of a read-modify-write never commits a partial update.
    assign mem_wr     = wr_raw & ~rst;
    assign mem_wdata  = mem_wr ? wword : 32'b0;
    assign mem_addr   = maddr_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            off_q   <= 2'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'b0;
            sgn_q   <= 1'b0;
            wdata_q <= 32'b0;
            rdata_q <= 32'b0;
            err_q   <= 1'b0;
            maddr_q <= 30'b0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            maddr_q <= maddr_d;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wr, req_signed;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_wr;

    always #5 clk = ~clk;

    mem_lsu dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wr(req_wr), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata)
    );

    // Synchronous word memory: read data appears the cycle after the address.
    logic [31:0] mem  [0:15];
    logic [31:0] refm [0:15];
    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr[3:0]];
        if (mem_wr) mem[mem_addr[3:0]] <= mem_wdata;
    end

    typedef struct { logic [31:0] rdata; logic err; } exp_t;
    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: byte-lane arithmetic on a word array.
    task automatic model(input logic [31:0] a, input logic wr, input logic [1:0] sz,
                         input logic sg, input logic [31:0] wd, output exp_t e,
                         output int lat, output int wcyc, output logic [31:0] wword);
        int w, off;
        logic [31:0] old, v, nw;
        w = int'(a[5:2]);
        off = int'(a[1:0]);
        old = refm[w];
        e.rdata = 32'd0; e.err = 1'b0; wcyc = -1; wword = 32'd0;
        if (sz == 2'd3 || (sz == 2'd1 && (off % 2) != 0) || (sz == 2'd2 && off != 0)) begin
            e.err = 1'b1; lat = 1;
        end else if (wr) begin
            nw = old;
            if (sz == 2'd2) begin nw = wd; lat = 2; wcyc = 1; end
            else begin
                if (sz == 2'd0) nw[8*off +: 8] = wd[7:0];
                else            nw[8*off +: 16] = wd[15:0];
                lat = 3; wcyc = 2;
            end
            refm[w] = nw;
            wword = nw;
        end else begin
            lat = 3;
            if (sz == 2'd0) begin
                v = (old >> (8*off)) & 32'hFF;
                if (sg && v >= 32'd128) v = v - 32'd256;
            end else if (sz == 2'd1) begin
                v = (old >> (8*off)) & 32'hFFFF;
                if (sg && v >= 32'd32768) v = v - 32'd65536;
            end else v = old;
            e.rdata = v;
        end
    endtask

    // Monitor: pops an expectation on every completed response handshake.
    always @(negedge clk) begin
        if (resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 32'(resp_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", 32'(resp_err), 32'(e.err));
            end
        end
    end

    task automatic txn(input logic [31:0] a, input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [31:0] wd, input int bp);
        exp_t e;
        int lat, wcyc, got, nwr, firstw;
        logic [31:0] wword, r0;
        logic e0;
        model(a, wr, sz, sg, wd, e, lat, wcyc, wword);
        exp_q.push_back(e);
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_addr = a; req_wr = wr; req_size = sz;
        req_signed = sg; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = $urandom; req_wr = 1'($urandom);
        req_size = 2'($urandom); req_signed = 1'($urandom); req_wdata = $urandom;
        got = 0; nwr = 0; firstw = -1;
        while (1) begin
            @(negedge clk);
            got++;
            if (mem_wr) begin
                nwr++;
                if (firstw < 0) firstw = got;
                chk("mem_addr", {2'b0, mem_addr}, a >> 2);
                chk("mem_wdata", mem_wdata, wword);
            end
            if (resp_valid || got > 20) break;
        end
        chk("latency", 32'(got), 32'(lat));
        chk("write_cycle", 32'(firstw), 32'(wcyc));
        chk("write_count", 32'(nwr), (wcyc < 0) ? 32'd0 : 32'd1);
        if (!resp_valid) begin
            void'(exp_q.pop_back());
            return;
        end
        r0 = resp_rdata; e0 = resp_err;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_rdata", resp_rdata, r0);
            chk("bp_err", 32'(resp_err), 32'(e0));
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk("idle_after_resp", 32'(req_ready), 32'd1);
        chk("valid_after_resp", 32'(resp_valid), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        chk({tag, "_mem_addr"}, {2'b0, mem_addr}, 32'd0);
        chk({tag, "_mem_wr"}, 32'(mem_wr), 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i] = $urandom;
            refm[i] = mem[i];
        end
        rst = 1'b1; req_valid = 1'b0; req_addr = 32'd0; req_wr = 1'b0;
        req_size = 2'd0; req_signed = 1'b0; req_wdata = 32'd0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        // Directed cases.
        txn(32'h10, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 0);
        txn(32'h10, 1'b0, 2'd2, 1'b0, 32'h0, 0);
        txn(32'h10, 1'b1, 2'd2, 1'b0, 32'h80FF7F01, 0);
        txn(32'h13, 1'b0, 2'd0, 1'b1, 32'h0, 0);
        txn(32'h13, 1'b0, 2'd0, 1'b0, 32'h0, 0);
        txn(32'h12, 1'b0, 2'd1, 1'b1, 32'h0, 0);
        txn(32'h10, 1'b1, 2'd2, 1'b0, 32'h11223344, 0);
        txn(32'h11, 1'b1, 2'd0, 1'b0, 32'hFFFFFFAA, 0);
        txn(32'h12, 1'b1, 2'd1, 1'b0, 32'hFFFF5566, 0);
        txn(32'h10, 1'b0, 2'd2, 1'b0, 32'h0, 0);
        txn(32'h12, 1'b0, 2'd2, 1'b0, 32'h0, 0);
        txn(32'h13, 1'b1, 2'd1, 1'b0, 32'h1234, 0);
        txn(32'h14, 1'b0, 2'd3, 1'b1, 32'h0, 0);
        txn(32'h10, 1'b0, 2'd2, 1'b0, 32'h0, 4);

        // Reset landing in the DATA cycle of a byte store.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h10; req_wr = 1'b1; req_size = 2'd0;
        req_wdata = 32'h77;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rmw_rd_no_wr", 32'(mem_wr), 32'd0);
        @(negedge clk);
        chk("rmw_data_wr", 32'(mem_wr), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_kills_wr", 32'(mem_wr), 32'd0);
        chk("rst_kills_wdata", mem_wdata, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("midrst");
        txn(32'h10, 1'b0, 2'd2, 1'b0, 32'h0, 0);

        // Random traffic.
        for (int n = 0; n < 250; n++) begin
            txn(32'($urandom_range(0, 63)), 1'($urandom), 2'($urandom), 1'($urandom),
                $urandom, int'($urandom_range(0, 3)));
        end

        repeat (2) @(negedge clk);
        for (int i = 0; i < 16; i++) chk("final_mem", mem[i], refm[i]);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit: the initiator side of one port of the dual-port word memory. Accepts byte-addressed load/store requests (byte, halfword, word) over a valid/ready handshake and turns them into word-port accesses. Loads are extracted and sign- or zero-extended. Sub-word stores are done as read-modify-write, because the memory port has no byte enables. Sits between the core's execute stage and one memory port.

## Interface
- No parameters; all widths fixed.
- clk  in  1  rising-edge clock, shared with the memory.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_addr  in  32  byte address.
- req_wr  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_signed  in  1  loads only: 1 sign-extends, 0 zero-extends.
- req_wdata  in  32  store data, right-aligned; only the low 8/16/32 bits are used.
- resp_valid  out  1  response present; held until accepted.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  misaligned access or reserved size.
- mem_addr  out  30  word address to the memory port.
- mem_wdata  out  32  write word; 0 whenever mem_wr=0.
- mem_wr  out  1  write strobe to the memory port.
- mem_rdata  in  32  memory read data; valid the cycle after the address is presented with mem_wr=0.

## Operation
- Byte order is little-endian: byte k sits in bits [8k+7:8k]. Halfword lane = addr[1].
- States: IDLE, RD, DATA, WR, RESP.
- IDLE
  - req_ready=1.
  - On req_valid, latch addr/wr/size/signed/wdata.
  - Error check: size=11, size=01 with addr[0]=1, or size=10 with addr[1:0]≠0. On error go to RESP with err=1 and no memory access.
  - Word store goes to WR. Load or sub-word store goes to RD.
- RD: mem_addr=latched addr[31:2], mem_wr=0. Go to DATA.
- DATA (mem_rdata valid)
  - Load: capture the extended lane into resp_rdata, go to RESP.
  - Sub-word store: mem_wdata = mem_rdata with the target lane replaced by wdata[7:0] or wdata[15:0], computed combinationally. mem_wr=1 this cycle. Go to RESP.
- WR: mem_wr=1, mem_wdata=latched wdata. Go to RESP.
- RESP: resp_valid=1. resp_rdata and resp_err stay stable while resp_valid=1 and resp_ready=0. On resp_ready go to IDLE.
- Only one request is in flight; no new request is accepted until the response completes.
- mem_addr holds its last value outside RD/DATA/WR.
- mem_wr = (state is WR or a store in DATA) AND !rst. No write is ever issued in a cycle where rst=1.
- Read-modify-write is not atomic with respect to the memory's other port. System software must not let the other port write the same word concurrently.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_addr=0, mem_wr=0, mem_wdata=0.
- Latency is counted from the accept edge (cycle 0) to the first cycle with resp_valid=1:
  - error: 1 cycle;
  - word store: 2 cycles (mem_wr=1 in cycle 1);
  - load: 3 cycles;
  - sub-word store: 3 cycles (mem_wr=1 in cycle 2).
- When resp_valid and resp_ready are both high, the response retires at that edge. The unit is in IDLE (req_ready=1) the next cycle. There is no same-cycle bypass from response to request.
- rst in any state returns the unit to IDLE at the next edge. Any response in flight is dropped, and no partial write is issued.

## Test plan
- Word store then load:
  - store addr 0x10, data 0xDEADBEEF → mem_wr=1 at mem_addr 0x4 in cycle 1, resp_valid in cycle 2, resp_err=0;
  - load word 0x10 → resp_rdata=0xDEADBEEF in cycle 3.
- Byte loads:
  - with word 0x4 = 0x80FF7F01, load byte 0x13 signed → 0xFFFFFF80;
  - load byte 0x13 unsigned → 0x00000080;
  - load half 0x12 signed → 0xFFFF80FF.
- Sub-word RMW:
  - word 0x4 = 0x11223344, store byte 0x11 data 0xAA → mem_wdata=0x1122AA44;
  - then store half 0x12 data 0x5566 → final word 0x55662A44 would be wrong; required final word is 0x5566AA44.
- Errors: each of the following gives resp_err=1 in cycle 1, resp_rdata=0, and no mem_wr:
  - load word 0x12;
  - store half 0x13;
  - size=11.
- Backpressure: hold resp_ready=0 for 5 cycles → resp_valid and data stay stable, req_ready=0; release → IDLE the next cycle.
- Reset mid-RMW: assert rst in the DATA cycle of a byte store → mem_wr=0 that cycle, the memory word is unchanged, and all outputs equal their reset values the next cycle.
